// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan controller feeding one shared dec7seg across NDIG hex digits.
// A one-entry pending buffer is applied only at frame boundaries so a frame never mixes values.
module hex_scan_ctrl #(
  parameter int NDIG = 4,
  parameter int DIV  = 50000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [4*NDIG-1:0] value_in,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              blank_lz,
  output logic [3:0]        digit_out,
  output logic [NDIG-1:0]   digit_sel,
  output logic              blank,
  output logic              frame_done
);

  localparam int DW = 4 * NDIG;
  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] disp_q, disp_d;
  logic [DW-1:0] pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          frame_done_q, frame_done_d;

  logic accept, tick, wrap, hi_zero;

  assign load_ready = !pend_full_q;
  assign accept     = load_valid && load_ready;
  assign tick       = (state_q == SCAN) && (pre_q == PRE_LAST);
  assign wrap       = tick && (idx_q == IDX_LAST);
  assign frame_done = frame_done_q;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q      <= IDLE;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      pre_q        <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    pre_d        = pre_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    digit_sel    = '1;
    blank        = 1'b1;
    digit_out    = 4'h0;
    hi_zero      = 1'b1;

    // Slot mux plus "all digits at or above idx are zero" for leading-zero blanking.
    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == idx_q) digit_out = disp_q[4*i +: 4];
      if (IW'(i) >= idx_q && disp_q[4*i +: 4] != 4'h0) hi_zero = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // First value bypasses the pending buffer so it shows on the next cycle.
        if (accept) begin
          state_d = SCAN;
          disp_d  = value_in;
        end
      end
      SCAN: begin
        digit_sel = ~(NDIG'(1) << idx_q);
        blank     = blank_lz && (idx_q != '0) && hi_zero;
        pre_d     = tick ? '0 : pre_q + PW'(1);
        if (tick) idx_d = wrap ? '0 : idx_q + IW'(1);
        frame_done_d = wrap;
        if (wrap && pend_full_q) begin
          disp_d      = pend_q;
          pend_full_d = 1'b0;
        end
        // accept implies pend_full_q == 0, so it never collides with the apply above.
        if (accept) begin
          pend_d      = value_in;
          pend_full_d = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench for hex_scan_ctrl (NDIG=4, DIV=4): expected slots and frame_done
// cycles are queued by the stimulus, a negedge monitor pops them on every select change.
module tb_hex_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic        load_valid = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load_ready;
  logic [3:0]  digit_out;
  logic [3:0]  digit_sel;
  logic        blank;
  logic        frame_done;

  int cyc  = 0;
  int nchk = 0;
  int nerr = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    int         cyc;
    logic [3:0] d;
    logic [3:0] sel;
    logic       b;
  } exp_t;

  exp_t       sq[$];
  int         fdq[$];
  exp_t       mon_e;
  logic [3:0] prev_sel = 4'b1111;

  hex_scan_ctrl #(.NDIG(4), .DIV(4)) dut (
    .CLOCK_50  (clk),
    .reset     (rst_n),
    .value_in  (value_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .blank_lz  (blank_lz),
    .digit_out (digit_out),
    .digit_sel (digit_sel),
    .blank     (blank),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Returns 1 time unit after posedge number c.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // bm: per-slot expected blank (bit k = slot k)
  task automatic push_frame(input int start, input logic [15:0] v, input logic [3:0] bm,
                            input int nslots, input bit fd);
    logic [3:0] one;
    exp_t       e;
    one = 4'b0001;
    for (int k = 0; k < nslots; k++) begin
      e.cyc = start + 4 * k;
      e.d   = v[4*k +: 4];
      e.sel = ~(one << k);
      e.b   = bm[k];
      sq.push_back(e);
    end
    if (fd) fdq.push_back(start + 16);
  endtask

  task automatic push_slot(input int c, input logic [3:0] d, input logic [3:0] sel, input logic b);
    exp_t e;
    e.cyc = c; e.d = d; e.sel = sel; e.b = b;
    sq.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (frame_done === 1'b1) begin
          if (fdq.size() == 0) chk("frame_done_unexpected", {31'b0, frame_done}, 32'd0);
          else                 chk("frame_done_cycle", cyc, fdq.pop_front());
        end
        if (digit_sel !== prev_sel) begin
          prev_sel = digit_sel;
          if (sq.size() == 0) begin
            chk("slot_unexpected", {23'b0, digit_out, digit_sel, blank}, 32'd0);
          end else begin
            mon_e = sq.pop_front();
            chk("slot_cycle", cyc, mon_e.cyc);
            chk("slot_out_sel_blank", {23'b0, digit_out, digit_sel, blank},
                {23'b0, mon_e.d, mon_e.sel, mon_e.b});
          end
        end
      end
    end
  end

  initial begin
    int f0;
    int a;

    // Reset held for two edges
    wait_until(2);
    chk("rst_sel", digit_sel, 4'hF);
    chk("rst_blank", blank, 1);
    chk("rst_ready", load_ready, 1);
    chk("rst_dout", digit_out, 0);
    chk("rst_fd", frame_done, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int c = 3; c <= 10; c++) begin
      wait_until(c);
      chk("idle_sel", digit_sel, 4'hF);
      chk("idle_blank", blank, 1);
      chk("idle_ready", load_ready, 1);
    end

    // First load from IDLE, accepted at edge f0
    f0 = 11;
    push_frame(f0,      16'h12AB, 4'b0000, 4, 1);
    push_frame(f0 + 16, 16'h12AB, 4'b0000, 4, 1);
    value_in = 16'h12AB; load_valid = 1'b1;
    wait_until(f0);
    load_valid = 1'b0; value_in = 16'h5555;

    // Mid-frame load while idx=1; an offer while full must be ignored
    wait_until(f0 + 20);
    push_frame(f0 + 32, 16'h0007, 4'b0000, 4, 1);
    value_in = 16'h0007; load_valid = 1'b1;
    wait_until(f0 + 21);
    load_valid = 1'b0; value_in = '0;
    chk("mid_ready_lo", load_ready, 0);
    wait_until(f0 + 25);
    value_in = 16'hDEAD; load_valid = 1'b1;
    wait_until(f0 + 27);
    load_valid = 1'b0; value_in = '0;
    wait_until(f0 + 31);
    chk("mid_ready_hold", load_ready, 0);
    wait_until(f0 + 32);
    chk("apply_ready", load_ready, 1);

    // Back-to-back: only the value present when ready was high is captured
    push_frame(f0 + 48, 16'h3456, 4'b0000, 4, 1);
    value_in = 16'h3456; load_valid = 1'b1;
    for (int c = f0 + 33; c <= f0 + 46; c++) begin
      wait_until(c);
      value_in = 16'hE000 ^ 16'(c);
      if (c == f0 + 40) chk("b2b_ready_lo", load_ready, 0);
    end
    wait_until(f0 + 47);
    load_valid = 1'b0;
    wait_until(f0 + 48);
    chk("b2b_ready_hi", load_ready, 1);

    // Leading-zero blanking on 0050 then 0000
    wait_until(f0 + 50);
    push_frame(f0 + 64, 16'h0050, 4'b1100, 4, 1);
    value_in = 16'h0050; load_valid = 1'b1;
    wait_until(f0 + 51);
    load_valid = 1'b0;
    wait_until(f0 + 62);
    blank_lz = 1'b1;
    wait_until(f0 + 66);
    push_frame(f0 + 80, 16'h0000, 4'b1110, 4, 1);
    push_frame(f0 + 96, 16'h0000, 4'b1110, 3, 0);
    value_in = 16'h0000; load_valid = 1'b1;
    wait_until(f0 + 67);
    load_valid = 1'b0;

    // Reset at idx=2 with a pending load held
    wait_until(f0 + 97);
    value_in = 16'hABCD; load_valid = 1'b1;
    wait_until(f0 + 98);
    load_valid = 1'b0;
    chk("pend_ready_lo", load_ready, 0);
    wait_until(f0 + 105);
    push_slot(f0 + 106, 4'h0, 4'hF, 1'b1);
    rst_n = 1'b0;
    wait_until(f0 + 106);
    rst_n = 1'b1;
    chk("midrst_ready", load_ready, 1);
    chk("midrst_fd", frame_done, 0);
    chk("midrst_dout", digit_out, 0);
    for (int c = f0 + 107; c <= f0 + 110; c++) begin
      wait_until(c);
      chk("midrst_idle_sel", digit_sel, 4'hF);
    end

    // Fresh IDLE load after reset goes straight to display
    a = f0 + 111;
    push_slot(a,     4'h1, 4'b1110, 1'b0);
    push_slot(a + 4, 4'h2, 4'b1101, 1'b0);
    value_in = 16'h4321; load_valid = 1'b1;
    wait_until(a);
    load_valid = 1'b0;
    wait_until(a + 6);
    mon_en = 1'b0;
    chk("slot_queue_empty", sq.size(), 0);
    chk("fd_queue_empty", fdq.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
